// File: rtl/control_unit_pipe.sv
// RV32I decode/control with an ID/EX register and MUL/DIV occupancy counter.
// Optional M-extension decode and counter are enabled by defining CU_MEXT_EN.
module control_unit_pipe #(
    parameter int ALUCTRL_W = 4,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          InstrD,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic [2:0]           ImmSrcD,
    output logic                 RegWriteE,
    output logic [1:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 JalrE,
    output logic                 BranchE,
    output logic                 ALUSrcAE,
    output logic                 ALUSrcBE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 IllegalE,
    output logic                 MduBusyE
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111, ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001, ALU_PASSB = 4'b1010;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;
    ctrl_t      d;
    ctrl_t      e;
    logic       mdu_busy;

    assign opcode       = InstrD[6:0];
    assign funct3       = InstrD[14:12];
    assign funct7       = InstrD[31:25];
    assign unused_instr = ^{InstrD[24:15], InstrD[11:7]};

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5, input logic is_reg);
        case (f3)
            3'b000:  alu_op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

`ifdef CU_MEXT_EN
    logic d_mul;
    logic d_div;
`endif

    always_comb begin
        d       = '0;
        ImmSrcD = 3'b000;
`ifdef CU_MEXT_EN
        d_mul   = 1'b0;
        d_div   = 1'b0;
`endif
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000001) begin
`ifdef CU_MEXT_EN
                    d.reg_write = 1'b1;
                    case (funct3)
                        3'b000:  begin d.alu_ctrl = 4'b1100; d_mul = 1'b1; end
                        3'b001:  begin d.alu_ctrl = 4'b1101; d_mul = 1'b1; end
                        3'b100:  begin d.alu_ctrl = 4'b1110; d_div = 1'b1; end
                        3'b110:  begin d.alu_ctrl = 4'b1111; d_div = 1'b1; end
                        default: begin d.reg_write = 1'b0; d.illegal = 1'b1; end
                    endcase
`else
                    d.illegal = 1'b1;
`endif
                end else begin
                    d.reg_write = 1'b1;
                    d.alu_ctrl  = alu_op(funct3, funct7[5], 1'b1);
                end
            end
            7'b0010011: begin
                d.reg_write = 1'b1;
                d.alu_src_b = 1'b1;
                d.alu_ctrl  = alu_op(funct3, funct7[5], 1'b0);
            end
            7'b0000011: begin
                d.reg_write  = 1'b1;
                d.result_src = 2'b01;
                d.alu_src_b  = 1'b1;
            end
            7'b0100011: begin
                ImmSrcD     = 3'b001;
                d.mem_write = 1'b1;
                d.alu_src_b = 1'b1;
            end
            7'b1100011: begin
                ImmSrcD    = 3'b010;
                d.branch   = 1'b1;
                d.alu_ctrl = ALU_SUB;
            end
            7'b1101111: begin
                ImmSrcD      = 3'b011;
                d.reg_write  = 1'b1;
                d.result_src = 2'b10;
                d.jump       = 1'b1;
            end
            7'b1100111: begin
                d.reg_write  = 1'b1;
                d.result_src = 2'b10;
                d.jump       = 1'b1;
                d.jalr       = 1'b1;
                d.alu_src_b  = 1'b1;
            end
            7'b0110111: begin
                ImmSrcD     = 3'b100;
                d.reg_write = 1'b1;
                d.alu_src_b = 1'b1;
                d.alu_ctrl  = ALU_PASSB;
            end
            7'b0010111: begin
                ImmSrcD     = 3'b100;
                d.reg_write = 1'b1;
                d.alu_src_a = 1'b1;
                d.alu_src_b = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
    end

    // Hand-off to E: a busy MDU freezes E outright; otherwise FlushE beats
    // StallE, and with neither asserted the D decode is captured every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            e <= '0;
        end else if (mdu_busy) begin
            e <= e;
        end else if (FlushE) begin
            e <= '0;
        end else if (!StallE) begin
            e <= d;
        end
    end

`ifdef CU_MEXT_EN
    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

    logic [5:0] mdu_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt <= '0;
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - 6'd1;
        end else if (!FlushE && !StallE) begin
            mdu_cnt <= d_mul ? MUL_LOAD : (d_div ? DIV_LOAD : 6'd0);
        end
    end

    assign mdu_busy = (mdu_cnt != '0);
`else
    assign mdu_busy = 1'b0;
`endif

    assign MduBusyE    = mdu_busy;
    assign RegWriteE   = e.reg_write;
    assign ResultSrcE  = e.result_src;
    assign MemWriteE   = e.mem_write;
    assign JumpE       = e.jump;
    assign JalrE       = e.jalr;
    assign BranchE     = e.branch;
    assign ALUSrcAE    = e.alu_src_a;
    assign ALUSrcBE    = e.alu_src_b;
    assign ALUControlE = ALUCTRL_W'(e.alu_ctrl);
    assign IllegalE    = e.illegal;

endmodule
